// File: rtl/task_fsm_multi_pipelined.sv
// task_fsm_multi_pipelined: launches each of NUM_TASKS pipelined HLS child tasks ITER times per
// accepted global start, tracking launches and completions separately per task.
module task_fsm_multi_pipelined #(
   parameter int NUM_TASKS   = 4,
   parameter int NUM_SCALARS = 2,
   parameter int SCALAR_W    = 32,
   parameter int CNT_W       = 16
) (
   input  logic                            ap_clk,
   input  logic                            ap_rst_n,
   input  logic [NUM_SCALARS*SCALAR_W-1:0] global_fsm_s_scalars,
   input  logic [CNT_W-1:0]                global_fsm_iter,
   input  logic                            global_fsm_ap_start,
   input  logic                            global_fsm_ap_done,
   output logic [NUM_SCALARS*SCALAR_W-1:0] task_s_scalars,
   output logic [NUM_TASKS-1:0]            task_ap_start,
   input  logic [NUM_TASKS-1:0]            task_ap_ready,
   input  logic [NUM_TASKS-1:0]            task_ap_done,
   input  logic [NUM_TASKS-1:0]            task_ap_idle,
   output logic [NUM_TASKS-1:0]            to_global_fsm_is_done,
   output logic                            all_tasks_done,
   output logic [NUM_TASKS-1:0]            task_err
);
   typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, DRAIN = 2'b11, DONE = 2'b10} state_t;
   logic [NUM_TASKS-1:0]            idle_v;
   logic                            accept;
   logic [CNT_W-1:0]                iter_q;
   logic [NUM_SCALARS*SCALAR_W-1:0] scalars_q;
   assign accept         = global_fsm_ap_start & (&idle_v);
   assign task_s_scalars = scalars_q;
   assign all_tasks_done = &to_global_fsm_is_done;
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         scalars_q <= '0;
         iter_q    <= CNT_W'(1);
      end else if (accept) begin
         scalars_q <= global_fsm_s_scalars;
         iter_q    <= global_fsm_iter == '0 ? CNT_W'(1) : global_fsm_iter;
      end
   end
   for (genvar i = 0; i < NUM_TASKS; i++) begin : g_task
      state_t           state, state_n;
      logic [CNT_W-1:0] lc, dc, lc_n, dc_n;
      logic             busy, launch, dn_ok, err, err_n, idle_run, idle_run_n;
      // A done is only legal while it does not overtake the launches seen so far, this cycle included.
      always_comb begin
         busy       = state == START || state == DRAIN;
         launch     = state == START && task_ap_ready[i];
         lc_n       = lc + CNT_W'(launch);
         dn_ok      = dc < lc_n;
         dc_n       = dc + CNT_W'(task_ap_done[i] && busy && dn_ok);
         idle_run_n = state == DRAIN && task_ap_idle[i] && dc < iter_q;
         err_n      = (accept ? 1'b0 : err) | (task_ap_done[i] && !(busy && dn_ok)) | (idle_run && idle_run_n);
         state_n    = state;
         case (state)
            IDLE:  state_n = accept ? START : IDLE;
            START: if (launch && lc_n == iter_q) state_n = dc_n == iter_q ? DONE : DRAIN;
            DRAIN: if (dc_n == iter_q) state_n = DONE;
            DONE:  if (global_fsm_ap_done) state_n = IDLE;
         endcase
      end
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            state    <= IDLE;
            lc       <= '0;
            dc       <= '0;
            err      <= 1'b0;
            idle_run <= 1'b0;
         end else begin
            state    <= state_n;
            lc       <= accept ? '0 : lc_n;
            dc       <= accept ? '0 : dc_n;
            err      <= err_n;
            idle_run <= idle_run_n;
         end
      end
      assign idle_v[i]                = state == IDLE;
      assign task_ap_start[i]         = state == START;
      assign to_global_fsm_is_done[i] = state == DONE;
      assign task_err[i]              = err;
   end
endmodule
